// File: rtl/instr_mem_pkg.sv
// Shared types and memory-map constants for the boot-time instruction memory loader.
// Instruction memory is a 4 KiB byte array mapped at the CPU reset vector.
package instr_mem_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        LOAD  = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } loader_state_t;

    localparam logic [31:0] IMEM_BYTES = 32'h0000_1000;
    localparam logic [31:0] IMEM_BASE  = 32'hBFC0_0000;

endpackage

// File: rtl/instr_mem_loader.sv
// Byte-stream boot loader: 4-byte LE length, payload written to imem, 1-byte XOR trailer.
// Memory write lands 1 cycle after acceptance; s_ready is low outside LEN/LOAD/CSUM, never stalls within them.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 8,
    parameter int MEM_BYTES     = int'(IMEM_BYTES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     s_valid,
    input  logic [DATA_WIDTH-1:0]    s_data,
    output logic                     s_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     cpu_stall,
    output logic                     done,
    output logic                     error,
    output logic [ADDRESS_WIDTH-1:0] byte_count
);

    loader_state_t              r_state;
    logic [31:0]                r_len;
    logic [1:0]                 r_len_idx;
    logic [DATA_WIDTH-1:0]      r_csum;
    logic [ADDRESS_WIDTH-1:0]   r_byte_count;
    logic                       r_mem_we;
    logic [ADDRESS_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]      r_mem_wdata;

    logic                       w_accept;
    logic                       w_rearm;
    logic [31:0]                w_len_full;
    logic [ADDRESS_WIDTH-1:0]   w_count_next;
    logic                       w_last_payload;

    assign s_ready   = (r_state == LEN) || (r_state == LOAD) || (r_state == CSUM);
    assign cpu_stall = (r_state != DONE);
    assign done      = (r_state == DONE);
    assign error     = (r_state == ERROR);

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign byte_count = r_byte_count;

    assign w_accept       = s_valid && s_ready;
    assign w_rearm        = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
    // Fourth length byte is still on the bus when the length is judged.
    assign w_len_full     = {s_data[7:0], r_len[23:0]};
    assign w_count_next   = r_byte_count + 1'b1;
    assign w_last_payload = (32'(w_count_next) == r_len);

    // Length assembly, least significant byte first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len     <= '0;
            r_len_idx <= '0;
        end else if (w_rearm) begin
            r_len     <= '0;
            r_len_idx <= '0;
        end else if ((r_state == LEN) && w_accept) begin
            r_len[{r_len_idx, 3'b000} +: 8] <= s_data[7:0];
            r_len_idx                       <= r_len_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_csum       <= '0;
            r_byte_count <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        r_state      <= LEN;
                        r_csum       <= '0;
                        r_byte_count <= '0;
                    end
                end
                LEN: begin
                    if (w_accept && (r_len_idx == 2'd3)) begin
                        if (w_len_full == 32'd0) begin
                            r_state <= CSUM;
                        end else if (w_len_full > 32'(MEM_BYTES)) begin
                            r_state <= ERROR;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= r_byte_count;
                        r_mem_wdata  <= s_data;
                        r_byte_count <= w_count_next;
                        r_csum       <= r_csum ^ s_data;
                        if (w_last_payload) begin
                            r_state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (w_accept) begin
                        r_state <= (s_data == r_csum) ? DONE : ERROR;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
